// File: rtl/ram_pattern_writer.sv
// RAM bring-up engine: fills a sync RAM with (addr + SEED), reads it back
// through a latency-matched compare pipeline, reports pass/err/fail_addr.
module ram_pattern_writer #(
    parameter int                 ADDR_W = 5,
    parameter int                 DATA_W = 8,
    parameter logic [DATA_W-1:0]  SEED   = 8'hA5,
    parameter int                 RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] fail_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE   = 1;
    localparam logic [ADDR_W:0]   ERR_ONE    = 1;
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ADDR_W:0]     err_q, err_d;
    logic [ADDR_W-1:0]   fail_q, fail_d;
    logic [1:0]          drain_q, drain_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [ADDR_W-1:0]   dly_q [RD_LAT];
    logic [ADDR_W-1:0]   dly_d [RD_LAT];

    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   exp_data;

    assign addr_nxt = addr_q + ADDR_ONE;
    assign exp_data = DATA_W'(dly_q[RD_LAT-1]) + SEED;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        din_d   = din_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;
        drain_d = drain_q;

        // Read issue tracking: address and valid ride along with RAM latency
        vld_d[0] = (state_q == S_READ);
        dly_d[0] = addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dly_d[i] = dly_q[i-1];
        end

        if (vld_q[RD_LAT-1] && (ram_dout != exp_data)) begin
            err_d = err_q + ERR_ONE;
            if (err_q == '0) begin
                fail_d = dly_q[RD_LAT-1];
            end
        end

        unique case (state_q)
            S_IDLE: begin
                we_d   = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    state_d = S_WRITE;
                    addr_d  = '0;
                    we_d    = 1'b1;
                    din_d   = SEED;
                    busy_d  = 1'b1;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    fail_d  = '0;
                end
            end
            S_WRITE: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    we_d    = 1'b0;
                    din_d   = '0;
                end else begin
                    addr_d = addr_nxt;
                    din_d  = DATA_W'(addr_nxt) + SEED;
                end
            end
            S_READ: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                    drain_d = '0;
                end else begin
                    addr_d = addr_nxt;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
            end
            default: begin
                state_d = S_IDLE;
                we_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
            drain_q <= '0;
            vld_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            drain_q <= drain_d;
            vld_q   <= vld_d;
            for (int i = 0; i < RD_LAT; i++) begin
                dly_q[i] <= dly_d[i];
            end
        end
    end

    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_din   = din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_addr = fail_q;

endmodule

// File: tb/tb_ram_pattern_writer.sv
// Bench for ram_pattern_writer: RAM models with injectable read corruption,
// run expectations queued at start and checked when done pulses.
module tb_ram_pattern_writer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       ram_we;
    logic [4:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] err_count;
    logic [4:0] fail_addr;

    logic       start2;
    logic       ram_we2;
    logic [4:0] ram_addr2;
    logic [7:0] ram_din2;
    logic [7:0] ram_dout2;
    logic       busy2;
    logic       done2;
    logic       pass2;
    logic [5:0] err_count2;
    logic [4:0] fail_addr2;

    logic [7:0]  mem  [32];
    logic [7:0]  mem2 [32];
    logic [31:0] corrupt;
    logic [7:0]  rd2_s1;

    typedef struct {
        int         lat;
        logic       pass;
        logic [5:0] err;
        logic [4:0] fa;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    ram_pattern_writer #(
        .ADDR_W(5), .DATA_W(8), .SEED(8'hA5), .RD_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_addr(fail_addr)
    );

    ram_pattern_writer #(
        .ADDR_W(5), .DATA_W(8), .SEED(8'hA5), .RD_LAT(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_din(ram_din2),
        .ram_dout(ram_dout2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err_count2), .fail_addr(fail_addr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync single-port RAM, 1-cycle registered read, bit0 flip on marked addrs
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr] ^ {7'b0, corrupt[ram_addr]};
    end

    always @(posedge clk) begin
        if (ram_we2) mem2[ram_addr2] <= ram_din2;
        rd2_s1    <= mem2[ram_addr2];
        ram_dout2 <= rd2_s1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller raises start before the next posedge; k counts edges from it.
    task automatic watch(input int drop_k, input int max_k, input bit chk_wr);
        int   k;
        exp_t e;
        k = 0;
        @(posedge clk);
        while (k <= max_k && sb.size() > 0) begin
            @(negedge clk);
            if (k == drop_k) start = 1'b0;
            if (chk_wr && k < 32) begin
                check("wr_we", ram_we, 1);
                check("wr_addr", ram_addr, k);
                check("wr_din", ram_din, 8'(k + 8'hA5));
            end
            if (chk_wr && k == 1) check("busy_run", busy, 1);
            if (chk_wr && k == 32) begin
                check("rd_we", ram_we, 0);
                check("rd_din", ram_din, 0);
                check("rd_addr", ram_addr, 0);
            end
            if (done) begin
                e = sb.pop_front();
                check("done_lat", k, e.lat);
                check("pass", pass, e.pass);
                check("err_count", err_count, e.err);
                check("fail_addr", fail_addr, e.fa);
                check("busy_done", busy, 0);
            end
            if (sb.size() > 0) begin
                @(posedge clk);
                k++;
            end
        end
        check("run_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run(input logic p, input logic [5:0] er,
                       input logic [4:0] fa, input bit chk_wr);
        @(negedge clk);
        start = 1'b1;
        sb.push_back('{lat: 66, pass: p, err: er, fa: fa});
        watch(0, 120, chk_wr);
    endtask

    initial begin
        int   k;
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        start2  = 1'b0;
        corrupt = '0;
        repeat (3) @(negedge clk);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_din", ram_din, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_fail", fail_addr, 0);
        check("rst_pass2", pass2, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: clean run
        run(1'b1, 6'd0, 5'd0, 1'b1);

        // 2: two corrupted reads
        corrupt = (32'd1 << 5) | (32'd1 << 17);
        run(1'b0, 6'd2, 5'd5, 1'b0);

        // 3: every read corrupted
        corrupt = '1;
        run(1'b0, 6'd32, 5'd0, 1'b0);
        corrupt = '0;

        // 4: reset mid-write at address 10
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(ram_we && ram_addr == 5'd10) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("abort_addr", ram_addr, 10);
        check("abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_we", ram_we, 0);
        check("abort_addr0", ram_addr, 0);
        check("abort_din", ram_din, 0);
        check("abort_busy0", busy, 0);
        check("abort_done", done, 0);
        check("abort_pass", pass, 0);
        check("abort_err", err_count, 0);
        check("abort_fail", fail_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b1, 6'd0, 5'd0, 1'b1);

        // 5: start held 200 cycles, back-to-back runs
        @(negedge clk);
        start = 1'b1;
        sb.push_back('{lat: 66,  pass: 1'b1, err: 6'd0, fa: 5'd0});
        sb.push_back('{lat: 133, pass: 1'b1, err: 6'd0, fa: 5'd0});
        sb.push_back('{lat: 200, pass: 1'b1, err: 6'd0, fa: 5'd0});
        watch(199, 260, 1'b0);
        @(negedge clk);
        check("idle_after_b2b", busy, 0);

        // 6: read latency 2
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (!done2 && k < 120) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check("lat2_done", k, 67);
        check("lat2_pass", pass2, 1);
        check("lat2_err", err_count2, 0);
        @(negedge clk);
        check("lat2_pulse", done2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
